// File: rtl/tmds_channel_decoder_if.sv
// Channel-decoder bus: raw deserializer word in, decoded symbol and lock status out.
interface tmds_channel_decoder_if;
  logic [9:0] din;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] bit_offset;
  logic       resync;

  // Deserializer / capture side
  modport master (output din, input de, data, ctrl, locked, bit_offset, resync);
  // Decoder side
  modport slave  (input din, output de, data, ctrl, locked, bit_offset, resync);
endinterface

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: finds the word boundary from control-token runs,
// then decodes pixel data, DE and the 2-bit control code.
module tmds_channel_decoder #(
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 2048,
  parameter int unsigned LOSS_TIMEOUT  = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  tmds_channel_decoder_if.slave bus
);
  localparam int unsigned RUN_W   = (CTRL_RUN > 1) ? $clog2(CTRL_RUN) : 1;
  localparam int unsigned DWELL_W = $clog2(SEARCH_WINDOW);
  localparam int unsigned LOSS_W  = $clog2(LOSS_TIMEOUT);

  localparam logic [9:0] TOK_00 = 10'h354;
  localparam logic [9:0] TOK_01 = 10'h0AB;
  localparam logic [9:0] TOK_10 = 10'h154;
  localparam logic [9:0] TOK_11 = 10'h2AB;

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [9:0]         prev_q, prev_d;
  logic [3:0]         off_q, off_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               locked_q, locked_d;
  logic               resync_q, resync_d;
  logic [9:0]         s1_win_q, s1_win_d;
  logic               s1_tok_q, s1_tok_d;
  logic [1:0]         s1_code_q, s1_code_d;
  logic               de_q, de_d;
  logic [7:0]         data_q, data_d;
  logic [1:0]         ctrl_q, ctrl_d;

  logic [19:0] cat_c;
  logic [9:0]  win_c;
  logic        tok_c;
  logic [1:0]  code_c;
  logic [3:0]  next_off_c;
  logic [7:0]  q_c;
  logic [7:0]  dec_c;

  // Select the 10-bit window at the current alignment from this and last word
  always_comb begin
    cat_c      = {bus.din, prev_q};
    win_c      = 10'(cat_c >> off_q);
    next_off_c = (off_q == 4'd9) ? 4'd0 : 4'(off_q + 4'd1);
  end

  // Control-token detect on the aligned window
  always_comb begin
    tok_c  = 1'b1;
    code_c = 2'b00;
    case (win_c)
      TOK_00:  code_c = 2'b00;
      TOK_01:  code_c = 2'b01;
      TOK_10:  code_c = 2'b10;
      TOK_11:  code_c = 2'b11;
      default: tok_c  = 1'b0;
    endcase
  end

  // Undo the transition-minimising encode of the stage-1 word
  always_comb begin
    q_c      = s1_win_q[9] ? ~s1_win_q[7:0] : s1_win_q[7:0];
    dec_c    = '0;
    dec_c[0] = q_c[0];
    for (int i = 1; i < 8; i++) begin
      dec_c[i] = s1_win_q[8] ? (q_c[i] ^ q_c[i-1]) : ~(q_c[i] ^ q_c[i-1]);
    end
  end

  // Alignment search / lock tracking and the two-stage datapath
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    run_d     = run_q;
    dwell_d   = dwell_q;
    loss_d    = loss_q;
    locked_d  = locked_q;
    resync_d  = 1'b0;
    prev_d    = bus.din;
    s1_win_d  = win_c;
    s1_tok_d  = tok_c;
    s1_code_d = code_c;

    case (state_q)
      SEARCH: begin
        // A completed run beats a dwell expiry in the same cycle
        if (tok_c && (run_q == RUN_W'(CTRL_RUN - 1))) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
          run_d    = '0;
          dwell_d  = '0;
          loss_d   = '0;
        end else if (dwell_q == DWELL_W'(SEARCH_WINDOW - 1)) begin
          off_d   = next_off_c;
          run_d   = '0;
          dwell_d = '0;
        end else begin
          run_d   = tok_c ? RUN_W'(run_q + RUN_W'(1)) : '0;
          dwell_d = DWELL_W'(dwell_q + DWELL_W'(1));
        end
      end
      LOCKED: begin
        if (tok_c) begin
          loss_d = '0;
        end else if (loss_q == LOSS_W'(LOSS_TIMEOUT - 1)) begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          resync_d = 1'b1;
          off_d    = next_off_c;
          run_d    = '0;
          dwell_d  = '0;
          loss_d   = '0;
        end else begin
          loss_d = LOSS_W'(loss_q + LOSS_W'(1));
        end
      end
      default: state_d = SEARCH;
    endcase

    // Outputs are gated by the lock state being registered alongside them
    de_d   = locked_d & ~s1_tok_q;
    data_d = (locked_d & ~s1_tok_q) ? dec_c : 8'h00;
    ctrl_d = (locked_d & s1_tok_q) ? s1_code_q : 2'b00;
  end

  // State and pipeline registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEARCH;
      prev_q    <= '0;
      off_q     <= '0;
      run_q     <= '0;
      dwell_q   <= '0;
      loss_q    <= '0;
      locked_q  <= 1'b0;
      resync_q  <= 1'b0;
      s1_win_q  <= '0;
      s1_tok_q  <= 1'b0;
      s1_code_q <= '0;
      de_q      <= 1'b0;
      data_q    <= '0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      off_q     <= off_d;
      run_q     <= run_d;
      dwell_q   <= dwell_d;
      loss_q    <= loss_d;
      locked_q  <= locked_d;
      resync_q  <= resync_d;
      s1_win_q  <= s1_win_d;
      s1_tok_q  <= s1_tok_d;
      s1_code_q <= s1_code_d;
      de_q      <= de_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign bus.de         = de_q;
  assign bus.data       = data_q;
  assign bus.ctrl       = ctrl_q;
  assign bus.locked     = locked_q;
  assign bus.bit_offset = off_q;
  assign bus.resync     = resync_q;
endmodule
